// File: rtl/frame_seq_pkg.sv
// Shared types for the frame sequencer: playback mode and speed codes,
// controller state encoding and ping-pong direction values.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP_FWD  = 2'b00,
        MODE_LOOP_REV  = 2'b01,
        MODE_PING_PONG = 2'b10,
        MODE_ONE_SHOT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SPEED_1X      = 2'b00,
        SPEED_2X      = 2'b01,
        SPEED_HALF    = 2'b10,
        SPEED_QUARTER = 2'b11
    } speed_e;

    typedef enum logic [1:0] {
        S_PAUSE = 2'b00,
        S_PLAY  = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/frame_rate_timer.sv
// Frame-rate timer: counts pclk cycles while enabled and pulses o_expire when
// the speed-selected limit is reached; holds its count while disabled.
module frame_rate_timer
    import frame_seq_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int FPS    = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_speed,
    output logic       o_expire
);

    localparam int PERIOD = CLK_HZ / FPS;
    localparam int HALF   = (PERIOD / 2 > 0) ? PERIOD / 2 : 1;
    localparam int TW     = $clog2(4 * PERIOD);

    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_last;

    always_comb begin
        // NOTE: default before the case so no path leaves w_last unassigned (no latch).
        w_last = TW'(PERIOD - 1);
        case (speed_e'(i_speed))
            SPEED_1X:      w_last = TW'(PERIOD - 1);
            SPEED_2X:      w_last = TW'(HALF - 1);
            SPEED_HALF:    w_last = TW'(2 * PERIOD - 1);
            SPEED_QUARTER: w_last = TW'(4 * PERIOD - 1);
        endcase
    end

    // A >= compare lets a speed change to a shorter limit expire at once.
    assign o_expire = i_en && (r_timer >= w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (o_expire) begin
            r_timer <= '0;
        end else if (i_en) begin
            r_timer <= r_timer + 1'b1;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame-sequencing controller: play/pause/step FSM, mode-dependent next frame,
// tear-free commit on the ven falling edge. FRAME_SEQ_PIXREG_EN registers rdata.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int NUM_FRAMES = 10,
    parameter int DW         = 12,
    parameter int CLK_HZ     = 50_000_000,
    parameter int FPS        = 12,
    parameter int IDX_W      = $clog2(NUM_FRAMES)
) (
    input  logic                     pclk,
    input  logic                     rstn,
    input  logic                     play,
    input  logic                     step,
    input  logic [1:0]               mode,
    input  logic [1:0]               speed,
    input  logic                     ven,
    input  logic [NUM_FRAMES*DW-1:0] frame_data,
    output logic [DW-1:0]            rdata,
    output logic [IDX_W-1:0]         frame_idx,
    output logic                     frame_tick,
    output logic                     done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

    state_e           r_state;
    logic [IDX_W-1:0] r_frame_idx;
    logic             r_tick;
    logic             r_done;
    logic             r_pending;
    logic             r_dir;
    logic             r_play_q;
    logic             r_step_q;
    logic             r_ven_q;
    logic [1:0]       r_mode_q;

    mode_e            w_mode;
    logic             w_expire;
    logic             w_timer_en;
    logic             w_play_rise;
    logic             w_step_rise;
    logic             w_commit;
    logic             w_set_pending;
    logic             w_pp_enter;
    logic             w_dir_eff;
    logic             w_next_dir;
    logic [IDX_W-1:0] w_next;
    logic [DW-1:0]    w_pix;

    assign w_mode        = mode_e'(mode);
    assign w_timer_en    = (r_state == S_PLAY);
    assign w_play_rise   = play && !r_play_q;
    assign w_step_rise   = step && !r_step_q;
    assign w_commit      = r_pending && r_ven_q && !ven;
    assign w_set_pending = (r_state == S_PLAY && w_expire) ||
                           (r_state == S_PAUSE && w_step_rise);
    assign w_pp_enter    = (w_mode == MODE_PING_PONG) && (r_mode_q != MODE_PING_PONG);
    assign w_dir_eff     = w_pp_enter ? DIR_FWD : r_dir;

    frame_rate_timer #(
        .CLK_HZ (CLK_HZ),
        .FPS    (FPS)
    ) u_timer (
        .clk      (pclk),
        .rst_n    (rstn),
        .i_en     (w_timer_en),
        .i_speed  (speed),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next     = r_frame_idx;
        w_next_dir = w_dir_eff;
        case (w_mode)
            MODE_LOOP_FWD: w_next = (r_frame_idx == LAST_IDX) ? '0 : r_frame_idx + 1'b1;
            MODE_LOOP_REV: w_next = (r_frame_idx == '0) ? LAST_IDX : r_frame_idx - 1'b1;
            MODE_PING_PONG: begin
                // Turning at an end frame moves straight to its neighbour, so ends never repeat.
                if (w_dir_eff == DIR_FWD) begin
                    if (r_frame_idx == LAST_IDX) begin
                        w_next     = r_frame_idx - 1'b1;
                        w_next_dir = DIR_REV;
                    end else begin
                        w_next = r_frame_idx + 1'b1;
                    end
                end else begin
                    if (r_frame_idx == '0) begin
                        w_next     = r_frame_idx + 1'b1;
                        w_next_dir = DIR_FWD;
                    end else begin
                        w_next = r_frame_idx - 1'b1;
                    end
                end
            end
            MODE_ONE_SHOT: if (r_frame_idx != LAST_IDX) w_next = r_frame_idx + 1'b1;
        endcase
    end

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_PAUSE;
            r_frame_idx <= '0;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
            r_pending   <= 1'b0;
            r_dir       <= DIR_FWD;
            r_play_q    <= 1'b0;
            r_step_q    <= 1'b0;
            r_ven_q     <= 1'b0;
            r_mode_q    <= MODE_LOOP_FWD;
        end else begin
            r_play_q <= play;
            r_step_q <= step;
            r_ven_q  <= ven;
            r_mode_q <= mode;
            r_tick   <= 1'b0;

            if (w_pp_enter) r_dir <= DIR_FWD;

            if (w_commit) begin
                r_frame_idx <= w_next;
                r_tick      <= (w_next != r_frame_idx);
                if (w_mode == MODE_PING_PONG) r_dir <= w_next_dir;
            end

            // A new request in the commit cycle survives as the next pending advance.
            if (w_set_pending)  r_pending <= 1'b1;
            else if (w_commit)  r_pending <= 1'b0;

            case (r_state)
                S_PAUSE: if (play) r_state <= S_PLAY;
                S_PLAY: begin
                    if (!play) begin
                        r_state <= S_PAUSE;
                    end else if (w_commit && w_mode == MODE_ONE_SHOT && w_next == LAST_IDX) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_pending <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (w_play_rise) begin
                        r_state     <= S_PLAY;
                        r_done      <= 1'b0;
                        r_frame_idx <= '0;
                        r_tick      <= (r_frame_idx != '0);
                        r_pending   <= 1'b0;
                    end else if (w_mode != MODE_ONE_SHOT) begin
                        r_state <= S_PAUSE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= S_PAUSE;
            endcase
        end
    end

    // Out-of-range indices fall through to frame 0.
    always_comb begin
        w_pix = frame_data[DW-1:0];
        for (int k = 1; k < NUM_FRAMES; k++) begin
            if (r_frame_idx == IDX_W'(k)) w_pix = frame_data[k*DW +: DW];
        end
    end

`ifdef FRAME_SEQ_PIXREG_EN
    logic [DW-1:0] r_rdata;

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) r_rdata <= '0;
        else       r_rdata <= w_pix;
    end

    assign rdata = r_rdata;
`else
    assign rdata = w_pix;
`endif

    assign frame_idx  = r_frame_idx;
    assign frame_tick = r_tick;
    assign done       = r_done;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: 4 frames, PERIOD=100 cycles, ven 250 high / 50 low.
module tb_frame_sequencer;

    localparam int NF = 4;
    localparam int DW = 12;

    logic             pclk;
    logic             rstn;
    logic             play;
    logic             step;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic             ven;
    logic [NF*DW-1:0] frame_data;
    logic [DW-1:0]    rdata;
    logic [1:0]       frame_idx;
    logic             frame_tick;
    logic             done;

    int   tests = 0;
    int   fails = 0;
    int   vcnt  = 0;
    logic v_cur = 1'b0;
    logic v_old = 1'b0;
    int   c;
    int   pp_seq [7] = '{1, 2, 3, 2, 1, 0, 1};

    frame_sequencer #(
        .NUM_FRAMES (NF),
        .DW         (DW),
        .CLK_HZ     (1200),
        .FPS        (12)
    ) dut (
        .pclk       (pclk),
        .rstn       (rstn),
        .play       (play),
        .step       (step),
        .mode       (mode),
        .speed      (speed),
        .ven        (ven),
        .frame_data (frame_data),
        .rdata      (rdata),
        .frame_idx  (frame_idx),
        .frame_tick (frame_tick),
        .done       (done)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pclk; v_cur/v_old hold ven as seen by the DUT at the last two edges.
    task automatic cyc();
        @(negedge pclk);
        v_old = v_cur;
        v_cur = ven;
        ven   = (vcnt < 250);
        vcnt  = (vcnt + 1) % 300;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic expect_tick(input string tag, input int exp_idx);
        int n = 0;
        cyc();
        while (frame_tick !== 1'b1 && n < 800) begin
            cyc();
            n++;
        end
        check({tag, " tick"}, 32'(frame_tick), 32'd1);
        if (frame_tick === 1'b1) begin
            check({tag, " idx"}, 32'(frame_idx), 32'(exp_idx));
            check({tag, " ven_fall"}, 32'({v_old, v_cur}), 32'd2);
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            cyc();
            if (frame_tick === 1'b1) cnt++;
        end
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        cycles(3);
        rstn = 1'b1;
        cyc();
    endtask

    initial begin
        rstn       = 1'b0;
        play       = 1'b0;
        step       = 1'b0;
        mode       = 2'b00;
        speed      = 2'b00;
        ven        = 1'b0;
        frame_data = {12'h333, 12'h222, 12'h111, 12'h000};
        cycles(3);

        check("reset idx",   32'(frame_idx),  32'd0);
        check("reset tick",  32'(frame_tick), 32'd0);
        check("reset done",  32'(done),       32'd0);
        check("reset rdata", 32'(rdata),      32'h000);
        rstn = 1'b1;
        cyc();

        // Loop-forward at 1x
        play = 1'b1;
        expect_tick("fwd1", 1);
`ifdef FRAME_SEQ_PIXREG_EN
        check("fwd1 rdata lag", 32'(rdata), 32'h000);
`else
        check("fwd1 rdata", 32'(rdata), 32'h111);
`endif
        cyc();
        check("fwd1 single tick", 32'(frame_tick), 32'd0);
        check("fwd1 rdata settled", 32'(rdata), 32'h111);
        expect_tick("fwd2", 2);
        expect_tick("fwd3", 3);
`ifdef FRAME_SEQ_PIXREG_EN
        check("fwd3 rdata lag", 32'(rdata), 32'h222);
`else
        check("fwd3 rdata", 32'(rdata), 32'h333);
`endif
        expect_tick("fwd wrap", 0);

        // Ping-pong at 2x
        play = 1'b0;
        reset_dut();
        mode  = 2'b10;
        speed = 2'b01;
        play  = 1'b1;
        for (int i = 0; i < 7; i++) expect_tick($sformatf("pp%0d", i), pp_seq[i]);

        // One-shot at 2x, then restart from DONE on a play rising edge
        play = 1'b0;
        reset_dut();
        mode  = 2'b11;
        speed = 2'b01;
        play  = 1'b1;
        expect_tick("os1", 1);
        check("os1 done", 32'(done), 32'd0);
        expect_tick("os2", 2);
        expect_tick("os3", 3);
        check("os3 done", 32'(done), 32'd1);
        count_ticks(400, c);
        check("os hold ticks", 32'(c), 32'd0);
        check("os hold idx", 32'(frame_idx), 32'd3);
        play = 1'b0;
        cycles(3);
        check("os paused done", 32'(done), 32'd1);
        play = 1'b1;
        cycles(2);
        check("os restart idx", 32'(frame_idx), 32'd0);
        check("os restart done", 32'(done), 32'd0);
        expect_tick("os resume", 1);

        // Paused: three steps inside one ven-high period collapse to one advance
        play = 1'b0;
        reset_dut();
        mode  = 2'b00;
        speed = 2'b11;
        for (int i = 0; i < 300 && vcnt != 10; i++) cyc();
        repeat (3) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            cycles(2);
        end
        expect_tick("step", 1);
        count_ticks(700, c);
        check("step collapse ticks", 32'(c), 32'd0);
        check("step collapse idx", 32'(frame_idx), 32'd1);

        // A step while playing adds nothing before the first 0.25x expiry
        play = 1'b1;
        cycles(3);
        step = 1'b1;
        cyc();
        step = 1'b0;
        count_ticks(340, c);
        check("step in play ticks", 32'(c), 32'd0);

        // Asynchronous reset with frame_idx=2 and an advance pending
        play = 1'b0;
        reset_dut();
        mode  = 2'b00;
        speed = 2'b01;
        play  = 1'b1;
        expect_tick("rst pre1", 1);
        expect_tick("rst pre2", 2);
        cycles(60);
        play = 1'b0;
        rstn = 1'b0;
        #1;
        check("async rst idx",   32'(frame_idx),  32'd0);
        check("async rst tick",  32'(frame_tick), 32'd0);
        check("async rst done",  32'(done),       32'd0);
        check("async rst rdata", 32'(rdata),      32'h000);
        cycles(2);
        rstn = 1'b1;
        count_ticks(400, c);
        check("post rst no commit", 32'(c), 32'd0);
        check("post rst idx", 32'(frame_idx), 32'd0);
        play = 1'b1;
        expect_tick("post rst play", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Parametrised frame-sequencing controller for the VGA video player: selects one of `NUM_FRAMES` ROM pixel buses and drives the current frame index. Adds the following over the fixed 10-frame looping player:
- play/pause control
- single-step
- four playback modes
- runtime speed select
- tear-free switching: a frame change commits only at the end of the active display region

Sits between the per-frame ROM bank and DDP.

## Interface
- `NUM_FRAMES`, 10, number of frames (2..256).
- `DW`, 12, pixel width in bits.
- `CLK_HZ`, 50_000_000, `pclk` frequency.
- `FPS`, 12, nominal frame rate at speed 1x.
- `IDX_W`, `$clog2(NUM_FRAMES)`, frame index width (derived).

Ports:
- `pclk`, in, 1, pixel clock.
- `rstn`, in, 1, asynchronous active-low reset.
- `play`, in, 1, level: 1 = run, 0 = pause.
- `step`, in, 1, rising edge requests one advance while paused.
- `mode`, in, 2, 00 loop-fwd, 01 loop-rev, 10 ping-pong, 11 one-shot.
- `speed`, in, 2, 00 1x, 01 2x, 10 0.5x, 11 0.25x.
- `ven`, in, 1, vertical display-enable from DST.
- `frame_data`, in, `NUM_FRAMES*DW`, flattened ROM outputs; frame k at `[k*DW +: DW]`.
- `rdata`, out, `DW`, pixel of the current frame, to DDP.
- `frame_idx`, out, `IDX_W`, current frame.
- `frame_tick`, out, 1, one-cycle pulse when `frame_idx` changes.
- `done`, out, 1, one-shot reached its last frame.

## Operation
- `PERIOD = CLK_HZ/FPS`.
- Timer limits by speed: 1x = `PERIOD`, 2x = `PERIOD/2`, 0.5x = `2*PERIOD`, 0.25x = `4*PERIOD`.
- Timer width holds `4*PERIOD-1`.
- FSM states:
  - `S_PAUSE` (reset state).
  - `S_PLAY`, entered when `play=1` in `S_PAUSE`.
  - `S_DONE`, entered from `S_PLAY` when one-shot commits frame `NUM_FRAMES-1`.
- Leaving states:
  - `S_PLAY` → `S_PAUSE` when `play=0`.
  - `S_DONE` → `S_PLAY` on a rising edge of `play`, with `frame_idx` loaded to 0.
  - `S_DONE` → `S_PAUSE` when `mode` ≠ 11.
- Timer:
  - In `S_PLAY`: counts; when `timer >= limit-1`, clears and sets `pending`.
  - In `S_PAUSE` and `S_DONE`: holds its value, not cleared.
- Step: a rising edge of `step` in `S_PAUSE` sets `pending`. Ignored in `S_PLAY` and `S_DONE`.
- `pending` is a single flag. Multiple requests before a commit collapse into one advance.
- Commit fires when `pending=1` and a `ven` falling edge is seen (`ven_q=1`, `ven=0`). On commit: `frame_idx <= next`, `pending <= 0`.
- `next` by mode:
  - Loop-fwd: `idx+1`, wrapping `NUM_FRAMES-1` → 0.
  - Loop-rev: `idx-1`, wrapping 0 → `NUM_FRAMES-1`.
  - Ping-pong: the internal `dir` bit flips on reaching 0 or `NUM_FRAMES-1`, so the sequence is 0,1,..,N-1,N-2,..,0,1. No end frame repeats.
  - One-shot: `idx+1`. At `NUM_FRAMES-1` there is no advance, and `done=1`.
- A mode change takes effect at the next commit. Entering ping-pong sets `dir` = forward.
- Simultaneous timer expiry and step: one advance.
- A commit and a step edge in the same cycle: the step is taken as the next `pending`.

## Timing
- Reset values:
  - `frame_idx=0`, `frame_tick=0`, `done=0`, `pending=0`, `timer=0`, `dir=fwd`, state `S_PAUSE`.
  - `rdata=0` when registered; `frame_data[0]` when combinational.
- Mid-operation reset returns everything to these values immediately (asynchronous). The first post-reset commit still waits for a `ven` falling edge.
- `frame_idx` updates on the clock edge that samples the `ven` falling edge. `frame_tick` is high in that same cycle.
- `step` and `play` edges are detected against a 1-cycle registered copy, giving a 1-cycle detection latency.
- `rdata` follows `frame_data`/`frame_idx` with the latency given under Configuration.

## Configuration
- `FRAME_SEQ_PIXREG_EN`
  - Defined: `rdata` is registered, one `pclk` of latency after `frame_data`, reset value 0. The integrator delays `hen`/`ven` into DDP by one cycle.
  - Undefined: `rdata` is a combinational mux of `frame_data` indexed by `frame_idx`. Out-of-range index selects frame 0.

## Structure
- `frame_seq_pkg`:
  - mode codes and speed codes as localparams/typedef enums.
  - the state enum `S_PAUSE`/`S_PLAY`/`S_DONE`.
- One sub-module, `frame_rate_timer`, owning the timer, speed limit select and expiry pulse. The FSM, commit logic and pixel mux stay in `frame_sequencer`.

## Test plan
Bench parameters: `CLK_HZ=1200`, `FPS=12`, `NUM_FRAMES=4`, so `PERIOD=100`. `ven` is a 300-cycle period: 250 high, 50 low.

- Loop-fwd at 1x, `play=1`: `frame_idx` runs 0,1,2,3,0. Each change lands on a `ven` falling edge with a single `frame_tick`, never mid-frame.
- Ping-pong at 2x for 3000 cycles: sequence 0,1,2,3,2,1,0,1 with no repeated end frame.
- One-shot from 0: stops at 3 with `done=1`. `play` toggled 0→1 gives `frame_idx=0`, `done=0`, playback resumes.
- Paused: three `step` pulses within one `ven` high period give exactly one advance, 0→1. A step while `play=1` produces no extra advance.
- `rstn` pulsed low with `frame_idx=2` and `pending=1`: all outputs return to reset values at once, and no commit occurs until a fresh expiry.
- Distinct `frame_data` values per frame (0x111·k): `rdata` equals `0x111*frame_idx`. It lags one cycle with `FRAME_SEQ_PIXREG_EN` and is same-cycle without it.
